// File: rtl/spec_acc_pkg.sv
// Shared types and helpers for the multi-gate power-spectrum accumulator.
package spec_acc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StFlush
   } acc_state_e;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spec_acc_multigate_if.sv
// Control, input-stream and output-stream signals of the spectrum accumulator.
interface spec_acc_multigate_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ACC_W      = 48,
   parameter int unsigned NFFT       = 1024,
   parameter int unsigned N_GATE_MAX = 16,
   parameter int unsigned ACC_CNT_W  = 16
) ();
   import spec_acc_pkg::*;

   localparam int unsigned BIN_W      = $clog2(NFFT);
   localparam int unsigned GATE_W     = clog2_min1(N_GATE_MAX);
   localparam int unsigned GATE_NUM_W = $clog2(N_GATE_MAX) + 1;

   logic                  start;
   logic [ACC_CNT_W-1:0]  acc_num;
   logic [GATE_NUM_W-1:0] gate_num;
   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  out_valid;
   logic [ACC_W-1:0]      out_data;
   logic [BIN_W-1:0]      out_bin;
   logic [GATE_W-1:0]     out_gate;
   logic                  busy;
   logic                  done;
   logic [ACC_CNT_W-1:0]  pulse_cnt;
   logic                  sat;

   modport master (
      output start, acc_num, gate_num, in_valid, in_data,
      input  out_valid, out_data, out_bin, out_gate, busy, done, pulse_cnt, sat
   );

   modport slave (
      input  start, acc_num, gate_num, in_valid, in_data,
      output out_valid, out_data, out_bin, out_gate, busy, done, pulse_cnt, sat
   );

endinterface

// File: rtl/spec_acc_ram.sv
// Simple dual-port accumulator store with one-cycle registered read.
module spec_acc_ram #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned WIDTH  = 48
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spec_acc_multigate.sv
// Bin-by-bin power-spectrum accumulator over N pulses and up to N_GATE_MAX range gates.
// Define SPEC_ACC_SAT_EN to clamp sums at full scale and report it on sat; otherwise sums wrap.
module spec_acc_multigate
   import spec_acc_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ACC_W      = 48,
   parameter int unsigned NFFT       = 1024,
   parameter int unsigned N_GATE_MAX = 16,
   parameter int unsigned ACC_CNT_W  = 16
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   spec_acc_multigate_if.slave bus
);

   localparam int unsigned BIN_W      = $clog2(NFFT);
   localparam int unsigned GATE_W     = clog2_min1(N_GATE_MAX);
   localparam int unsigned GATE_NUM_W = $clog2(N_GATE_MAX) + 1;
   localparam int unsigned ADDR_W     = BIN_W + GATE_W;

   acc_state_e           state_q, state_d;
   logic [ACC_CNT_W-1:0] acc_last_q, acc_last_d;
   logic [ACC_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [GATE_W-1:0]    gate_last_q, gate_last_d;
   logic [GATE_W-1:0]    gate_q, gate_d;
   logic [BIN_W-1:0]     bin_q, bin_d;
   logic                 flush_q, flush_d;
   logic                 done_q, done_d;

   logic accept, last_bin, last_gate, first_pulse, final_pulse;

   logic              s1_valid_q, s1_first_q, s1_final_q;
   logic [BIN_W-1:0]  s1_bin_q;
   logic [GATE_W-1:0] s1_gate_q;
   logic [DATA_W-1:0] s1_data_q;

   logic              out_valid_q;
   logic [ACC_W-1:0]  out_data_q;
   logic [BIN_W-1:0]  out_bin_q;
   logic [GATE_W-1:0] out_gate_q;

   logic [ACC_W-1:0] ram_rdata, prev, sum;

   assign accept      = bus.in_valid && (state_q == StAccum);
   assign last_bin    = (bin_q == BIN_W'(NFFT - 1));
   assign last_gate   = (gate_q == gate_last_q);
   assign first_pulse = (pulse_cnt_q == '0);
   assign final_pulse = (pulse_cnt_q == acc_last_q);

   always_comb begin
      state_d     = state_q;
      acc_last_d  = acc_last_q;
      gate_last_d = gate_last_q;
      pulse_cnt_d = pulse_cnt_q;
      gate_d      = gate_q;
      bin_d       = bin_q;
      flush_d     = flush_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d     = StAccum;
               acc_last_d  = (bus.acc_num == '0) ? '0 : bus.acc_num - ACC_CNT_W'(1);
               if (bus.gate_num == '0) begin
                  gate_last_d = '0;
               end else if (bus.gate_num > GATE_NUM_W'(N_GATE_MAX)) begin
                  gate_last_d = GATE_W'(N_GATE_MAX - 1);
               end else begin
                  gate_last_d = GATE_W'(bus.gate_num - GATE_NUM_W'(1));
               end
               pulse_cnt_d = '0;
               gate_d      = '0;
               bin_d       = '0;
            end
         end
         StAccum: begin
            if (accept) begin
               bin_d = bin_q + BIN_W'(1);
               if (last_bin) begin
                  gate_d = gate_q + GATE_W'(1);
                  if (last_gate) begin
                     gate_d      = '0;
                     pulse_cnt_d = pulse_cnt_q + ACC_CNT_W'(1);
                     if (final_pulse) begin
                        state_d = StFlush;
                        flush_d = 1'b0;
                     end
                  end
               end
            end
         end
         StFlush: begin
            // Two cycles lets the last sample clear both pipeline stages.
            flush_d = 1'b1;
            if (flush_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         acc_last_q  <= '0;
         gate_last_q <= '0;
         pulse_cnt_q <= '0;
         gate_q      <= '0;
         bin_q       <= '0;
         flush_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_last_q  <= acc_last_d;
         gate_last_q <= gate_last_d;
         pulse_cnt_q <= pulse_cnt_d;
         gate_q      <= gate_d;
         bin_q       <= bin_d;
         flush_q     <= flush_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_final_q <= 1'b0;
         s1_bin_q   <= '0;
         s1_gate_q  <= '0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_first_q <= first_pulse;
            s1_final_q <= final_pulse;
            s1_bin_q   <= bin_q;
            s1_gate_q  <= gate_q;
            s1_data_q  <= bus.in_data;
         end
      end
   end

   spec_acc_ram #(
      .ADDR_W (ADDR_W),
      .WIDTH  (ACC_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (s1_valid_q),
      .waddr_i ({s1_gate_q, s1_bin_q}),
      .wdata_i (sum),
      .re_i    (accept),
      .raddr_i ({gate_q, bin_q}),
      .rdata_o (ram_rdata)
   );

   // First pulse ignores RAM so no clear pass is needed between jobs.
   assign prev = s1_first_q ? '0 : ram_rdata;

`ifdef SPEC_ACC_SAT_EN
   localparam int unsigned SUM_W = ACC_W + 1;

   logic [SUM_W-1:0] sum_wide;
   logic             clamp;
   logic             sat_q;

   assign sum_wide = {1'b0, prev} + SUM_W'(s1_data_q);
   assign clamp    = sum_wide[ACC_W];
   assign sum      = clamp ? '1 : sum_wide[ACC_W-1:0];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sat_q <= 1'b0;
      end else if ((state_q == StIdle) && bus.start) begin
         sat_q <= 1'b0;
      end else if (s1_valid_q && clamp) begin
         sat_q <= 1'b1;
      end
   end

   assign bus.sat = sat_q;
`else
   assign sum     = prev + ACC_W'(s1_data_q);
   assign bus.sat = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_bin_q   <= '0;
         out_gate_q  <= '0;
      end else begin
         out_valid_q <= s1_valid_q && s1_final_q;
         if (s1_valid_q && s1_final_q) begin
            out_data_q <= sum;
            out_bin_q  <= s1_bin_q;
            out_gate_q <= s1_gate_q;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_bin   = out_bin_q;
   assign bus.out_gate  = out_gate_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.pulse_cnt = pulse_cnt_q;

endmodule
